// File: rtl/ballot_scheduler.sv
// ballot_scheduler
//   Front-end controller for the voting machine. Qualifies the four raw
//   candidate buttons by hold time, rejects multi-button presses, offers
//   exactly one vote per physical press to the count datapath over a
//   valid/ready handshake, and scans candidate indices in result mode.
//
// Optional build macro:
//   LOCKOUT_EN - after each accepted vote the controller sits in a LOCK
//                state for LOCK_CYCLES cycles (presses ignored, busy=1)
//                before waiting for button release. Undefined by default.
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   asynchronous active-high reset, clears all state
//   mode          in   0 = voting, 1 = result display
//   button1..4    in   raw candidate buttons (already synchronous to clk)
//   vote_valid    out  a vote is offered to the count datapath
//   vote_cand     out  offered candidate index (button1 -> 0 ... button4 -> 3)
//   vote_ready    in   count datapath accepts the offered vote
//   disp_cand     out  candidate index selected for display
//   disp_en       out  high while in result mode
//   reject        out  one-cycle pulse when a multi-button press is rejected
//   busy          out  high in any state other than IDLE and RESULT
//   ballots_cast  out  accepted-vote count, saturating at all-ones
module ballot_scheduler #(
    parameter int HOLD_CYCLES = 10,
    parameter int DISP_CYCLES = 16,
    parameter int CNT_W       = 8,
    parameter int LOCK_CYCLES = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mode,
    input  logic             button1,
    input  logic             button2,
    input  logic             button3,
    input  logic             button4,
    output logic             vote_valid,
    output logic [1:0]       vote_cand,
    input  logic             vote_ready,
    output logic [1:0]       disp_cand,
    output logic             disp_en,
    output logic             reject,
    output logic             busy,
    output logic [CNT_W-1:0] ballots_cast
);

    localparam int DT_W = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;

    localparam logic [7:0]      HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [DT_W-1:0] DISP_LAST = DT_W'(DISP_CYCLES - 1);

    // Reject illegal parameterisations at elaboration time.
    if (HOLD_CYCLES < 2 || HOLD_CYCLES > 255 || DISP_CYCLES < 1 ||
        CNT_W < 1 || LOCK_CYCLES < 1) begin : g_param_check
        $error("ballot_scheduler: illegal parameter value");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_QUALIFY = 3'd1,
        S_ISSUE   = 3'd2,
        S_RELEASE = 3'd3,
`ifdef LOCKOUT_EN
        S_RESULT  = 3'd4,
        S_LOCK    = 3'd5
`else
        S_RESULT  = 3'd4
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [7:0]       hold_q, hold_d;
    logic [1:0]       disp_q, disp_d;
    logic [DT_W-1:0]  tmr_q, tmr_d;
    logic [CNT_W-1:0] cast_q, cast_d;
    logic             reject_q, reject_d;

`ifdef LOCKOUT_EN
    localparam int LK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [LK_W-1:0] LOCK_LAST = LK_W'(LOCK_CYCLES - 1);
    logic [LK_W-1:0]  lock_q, lock_d;
`endif

    logic [3:0] btn;
    logic [2:0] btn_cnt;
    logic [1:0] btn_idx;
    logic       held_same;

    assign btn     = {button4, button3, button2, button1};
    assign btn_cnt = {2'b00, button1} + {2'b00, button2} +
                     {2'b00, button3} + {2'b00, button4};

    // Index of the single pressed button; only meaningful when btn_cnt == 1.
    always_comb begin
        btn_idx = 2'd0;
        case (btn)
            4'b0010: btn_idx = 2'd1;
            4'b0100: btn_idx = 2'd2;
            4'b1000: btn_idx = 2'd3;
            default: btn_idx = 2'd0;
        endcase
    end

    // The press keeps qualifying only while the latched button is the one
    // and only button held.
    assign held_same = (btn_cnt == 3'd1) && btn[idx_q];

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        hold_d   = '0;
        disp_d   = '0;
        tmr_d    = '0;
        cast_d   = cast_q;
        reject_d = 1'b0;
`ifdef LOCKOUT_EN
        lock_d   = '0;
`endif
        case (state_q)
            S_IDLE: begin
                if (mode) begin
                    state_d = S_RESULT;
                end else if (btn_cnt == 3'd1) begin
                    state_d = S_QUALIFY;
                    idx_d   = btn_idx;
                    hold_d  = 8'd1;
                end else if (btn_cnt > 3'd1) begin
                    reject_d = 1'b1;
                    state_d  = S_RELEASE;
                end
            end
            S_QUALIFY: begin
                if (mode) begin
                    state_d = S_RESULT;
                end else if (btn_cnt > 3'd1) begin
                    reject_d = 1'b1;
                    state_d  = S_RELEASE;
                end else if (held_same) begin
                    hold_d = hold_q + 8'd1;
                    if (hold_q == HOLD_LAST) begin
                        state_d = S_ISSUE;
                    end
                end else begin
                    // Short presses are glitches: drop silently.
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                // Mode and buttons are ignored until the handshake completes.
                if (vote_ready) begin
                    if (cast_q != '1) begin
                        cast_d = cast_q + CNT_W'(1);
                    end
`ifdef LOCKOUT_EN
                    state_d = S_LOCK;
`else
                    state_d = S_RELEASE;
`endif
                end
            end
            S_RELEASE: begin
                if (btn_cnt == 3'd0) begin
                    state_d = mode ? S_RESULT : S_IDLE;
                end
            end
            S_RESULT: begin
                if (!mode) begin
                    // Route through RELEASE so a button already held
                    // cannot turn into a vote.
                    state_d = S_RELEASE;
                end else if (tmr_q == DISP_LAST) begin
                    disp_d = disp_q + 2'd1;
                end else begin
                    tmr_d  = tmr_q + DT_W'(1);
                    disp_d = disp_q;
                end
            end
`ifdef LOCKOUT_EN
            S_LOCK: begin
                if (lock_q == LOCK_LAST) begin
                    state_d = S_RELEASE;
                end else begin
                    lock_d = lock_q + LK_W'(1);
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            hold_q   <= '0;
            disp_q   <= '0;
            tmr_q    <= '0;
            cast_q   <= '0;
            reject_q <= 1'b0;
`ifdef LOCKOUT_EN
            lock_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            hold_q   <= hold_d;
            disp_q   <= disp_d;
            tmr_q    <= tmr_d;
            cast_q   <= cast_d;
            reject_q <= reject_d;
`ifdef LOCKOUT_EN
            lock_q   <= lock_d;
`endif
        end
    end

    assign vote_valid   = (state_q == S_ISSUE);
    assign vote_cand    = idx_q;
    assign disp_en      = (state_q == S_RESULT);
    assign disp_cand    = disp_q;
    assign reject       = reject_q;
    assign busy         = (state_q != S_IDLE) && (state_q != S_RESULT);
    assign ballots_cast = cast_q;

endmodule

// File: tb/tb_ballot_scheduler.sv
// Self-checking bench for ballot_scheduler. Two instances share stimulus:
// the default one and one with CNT_W=2 to exercise counter saturation.
// A behavioural model tracks the press/vote/display rules and every cycle's
// outputs are compared against it; a few scenario-level counts are also
// checked directly.
module tb_ballot_scheduler;

    localparam int HOLD  = 10;
    localparam int DISP  = 16;
    localparam int LOCKC = 32;
`ifdef LOCKOUT_EN
    localparam bit LOCK_ON = 1'b1;
`else
    localparam bit LOCK_ON = 1'b0;
`endif

    logic       clk        = 1'b0;
    logic       reset      = 1'b1;
    logic       mode       = 1'b0;
    logic       vote_ready = 1'b0;
    logic [3:0] btn        = 4'b0000;

    logic       vote_valid, disp_en, reject, busy;
    logic [1:0] vote_cand, disp_cand;
    logic [7:0] ballots_cast;

    logic       s_vote_valid, s_disp_en, s_reject, s_busy;
    logic [1:0] s_vote_cand, s_disp_cand;
    logic [1:0] s_ballots;

    always #5 clk = ~clk;

    ballot_scheduler #(.HOLD_CYCLES(HOLD), .DISP_CYCLES(DISP), .CNT_W(8), .LOCK_CYCLES(LOCKC)) u_dut (
        .clk(clk), .reset(reset), .mode(mode),
        .button1(btn[0]), .button2(btn[1]), .button3(btn[2]), .button4(btn[3]),
        .vote_valid(vote_valid), .vote_cand(vote_cand), .vote_ready(vote_ready),
        .disp_cand(disp_cand), .disp_en(disp_en), .reject(reject), .busy(busy),
        .ballots_cast(ballots_cast)
    );

    ballot_scheduler #(.HOLD_CYCLES(HOLD), .DISP_CYCLES(DISP), .CNT_W(2), .LOCK_CYCLES(LOCKC)) u_sat (
        .clk(clk), .reset(reset), .mode(mode),
        .button1(btn[0]), .button2(btn[1]), .button3(btn[2]), .button4(btn[3]),
        .vote_valid(s_vote_valid), .vote_cand(s_vote_cand), .vote_ready(vote_ready),
        .disp_cand(s_disp_cand), .disp_en(s_disp_en), .reject(s_reject), .busy(s_busy),
        .ballots_cast(s_ballots)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_result;      // showing results
    int m_res_age;     // cycles spent scanning in result mode
    bit m_release;     // must see all buttons up before anything else
    int m_press;       // button being qualified, -1 if none
    int m_plen;        // consecutive cycles that button has been held
    bit m_offer;       // vote currently offered
    int m_ocand;
    int m_lock;        // lockout cycles remaining
    int m_votes;       // accepted votes
    bit m_rej;         // reject pulse expected this cycle

    task automatic model_reset();
        m_result = 0; m_res_age = 0; m_release = 0; m_press = -1; m_plen = 0;
        m_offer = 0; m_ocand = 0; m_lock = 0; m_votes = 0; m_rej = 0;
    endtask

    task automatic model_step(input logic [3:0] b, input logic m, input logic r);
        int n;
        int hot;
        n   = $countones(b);
        hot = -1;
        for (int i = 0; i < 4; i++) if (b[i]) hot = i;
        m_rej = 0;
        if (m_offer) begin
            if (r) begin
                m_votes++;
                m_offer = 0;
                if (LOCK_ON) m_lock = LOCKC;
                else m_release = 1;
            end
        end else if (m_lock > 0) begin
            m_lock--;
            if (m_lock == 0) m_release = 1;
        end else if (m_release) begin
            if (n == 0) begin
                m_release = 0;
                if (m) begin m_result = 1; m_res_age = 0; end
            end
        end else if (m_result) begin
            if (!m) begin m_result = 0; m_release = 1; end
            else m_res_age++;
        end else if (m_press >= 0) begin
            if (m) begin
                m_press = -1; m_result = 1; m_res_age = 0;
            end else if (n > 1) begin
                m_press = -1; m_rej = 1; m_release = 1;
            end else if (n == 1 && hot == m_press) begin
                m_plen++;
                if (m_plen == HOLD) begin
                    m_offer = 1; m_ocand = m_press; m_press = -1;
                end
            end else begin
                m_press = -1;
            end
        end else begin
            if (m) begin
                m_result = 1; m_res_age = 0;
            end else if (n == 1) begin
                m_press = hot; m_plen = 1;
            end else if (n > 1) begin
                m_rej = 1; m_release = 1;
            end
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic compare_all();
        logic m_busy;
        int   exp_disp;
        m_busy   = m_offer || (m_lock > 0) || m_release || (m_press >= 0);
        exp_disp = m_result ? ((m_res_age / DISP) % 4) : 0;
        chk("vote_valid", vote_valid, m_offer);
        if (m_offer) chk("vote_cand", vote_cand, m_ocand);
        chk("reject", reject, m_rej);
        chk("busy", busy, m_busy);
        chk("disp_en", disp_en, m_result);
        chk("disp_cand", disp_cand, exp_disp);
        chk("ballots_cast", ballots_cast, sat(m_votes, 255));
        chk("sat_vote_valid", s_vote_valid, m_offer);
        if (m_offer) chk("sat_vote_cand", s_vote_cand, m_ocand);
        chk("sat_reject", s_reject, m_rej);
        chk("sat_busy", s_busy, m_busy);
        chk("sat_disp_en", s_disp_en, m_result);
        chk("sat_disp_cand", s_disp_cand, exp_disp);
        chk("sat_ballots", s_ballots, sat(m_votes, 3));
    endtask

    // ---------------- stimulus helpers ----------------
    int cyc         = 0;
    int vcyc        = 0;   // cycles vote_valid observed high
    int rcnt        = 0;   // reject pulses observed
    int first_valid = -1;  // cycle index of first vote_valid seen
    int rdy_after   = -1;  // >=0: assert ready once vcyc exceeds this

    task automatic clr_obs();
        vcyc = 0; rcnt = 0; first_valid = -1;
    endtask

    // Check the current cycle, then drive the inputs for it.
    task automatic tick(input logic [3:0] b, input logic m, input logic r);
        @(negedge clk);
        compare_all();
        if (vote_valid) vcyc++;
        if (reject) rcnt++;
        if (vote_valid && first_valid < 0) first_valid = cyc;
        btn  = b;
        mode = m;
        vote_ready = (rdy_after >= 0) ? (vcyc > rdy_after) : r;
        model_step(b, m, vote_ready);
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(4'b0000, 1'b0, 1'b0);
    endtask

    function automatic logic rnd_rdy();
        return ($urandom_range(0, 2) != 0);
    endfunction

    initial begin
        int t0;
        bit seen;
        model_reset();

        // Reset state
        #1;
        chk("rst_vote_valid", vote_valid, 0);
        chk("rst_vote_cand", vote_cand, 0);
        chk("rst_disp_cand", disp_cand, 0);
        chk("rst_disp_en", disp_en, 0);
        chk("rst_reject", reject, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ballots", ballots_cast, 0);
        @(negedge clk);
        reset = 1'b0;
        model_step(4'b0000, 1'b0, 1'b0);

        // Glitch: one-cycle press
        clr_obs();
        tick(4'b0001, 1'b0, 1'b1);
        idle(6);
        chk("glitch_valid", vcyc, 0);
        chk("glitch_reject", rcnt, 0);
        chk("glitch_ballots", ballots_cast, 0);

        // Valid press with latency measurement
        clr_obs();
        t0 = cyc;
        repeat (20) tick(4'b0001, 1'b0, 1'b1);
        idle(3);
        chk("press_latency", first_valid - t0, HOLD);
        chk("press_valid_cycles", vcyc, 1);
        chk("press_ballots", ballots_cast, 1);
        idle(40);

        // Back-pressure: ready low for 5 valid cycles
        clr_obs();
        rdy_after = 5;
        repeat (20) tick(4'b1000, 1'b0, 1'b0);
        repeat (3) tick(4'b0000, 1'b0, 1'b0);
        rdy_after = -1;
        chk("bp_valid_cycles", vcyc, 6);
        chk("bp_ballots", ballots_cast, 2);
        idle(40);

        // Simultaneous press, then a clean button2 press
        clr_obs();
        repeat (20) tick(4'b0110, 1'b0, 1'b1);
        idle(3);
        chk("multi_reject", rcnt, 1);
        chk("multi_valid", vcyc, 0);
        chk("multi_ballots", ballots_cast, 2);
        clr_obs();
        repeat (20) tick(4'b0010, 1'b0, 1'b1);
        idle(3);
        chk("b2_valid_cycles", vcyc, 1);
        chk("b2_ballots", ballots_cast, 3);
        idle(40);

        // Result mode with random button noise
        clr_obs();
        repeat (80) tick(4'($urandom_range(0, 15)), 1'b1, 1'b1);
        chk("result_valid", vcyc, 0);
        clr_obs();
        repeat (20) tick(4'b0100, 1'b0, 1'b1);
        idle(3);
        chk("held_after_result", vcyc, 0);
        clr_obs();
        repeat (20) tick(4'b0100, 1'b0, 1'b1);
        idle(3);
        chk("repress_valid", vcyc, 1);
        idle(40);

        // Re-press shortly after a vote
        repeat (20) tick(4'b0001, 1'b0, 1'b1);
        idle(3);
        clr_obs();
        repeat (15) tick(4'b0001, 1'b0, 1'b1);
        idle(3);
        chk("lockout_repress", vcyc, LOCK_ON ? 0 : 1);
        idle(40);

        // At least five votes accepted by now
        chk("sat_cnt_w2", s_ballots, 3);

        // Reset during ISSUE
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick(4'b0001, 1'b0, 1'b0);
            if (vote_valid) seen = 1;
        end
        chk("rst_issue_reached", seen, 1);
        #2;
        reset = 1'b1; btn = 4'b0000; mode = 1'b0; vote_ready = 1'b0;
        #1;
        chk("rst_issue_valid", vote_valid, 0);
        chk("rst_issue_ballots", ballots_cast, 0);
        chk("rst_issue_sat_ballots", s_ballots, 0);
        chk("rst_issue_busy", busy, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        model_step(4'b0000, 1'b0, 1'b0);

        // Randomised segments
        for (int s = 0; s < 80; s++) begin
            int kind;
            int len;
            logic [3:0] b;
            kind = $urandom_range(0, 4);
            case (kind)
                0: begin
                    b   = 4'b0001 << $urandom_range(0, 3);
                    len = $urandom_range(1, 25);
                    repeat (len) tick(b, 1'b0, rnd_rdy());
                end
                1: begin
                    b = 4'($urandom_range(0, 15));
                    if ($countones(b) < 2) b = 4'b1010;
                    len = $urandom_range(1, 10);
                    repeat (len) tick(b, 1'b0, rnd_rdy());
                end
                2: begin
                    len = $urandom_range(1, 40);
                    repeat (len) tick(4'b0000, 1'b0, rnd_rdy());
                end
                3: begin
                    len = $urandom_range(1, 50);
                    repeat (len) tick(4'($urandom_range(0, 15)), 1'b1, rnd_rdy());
                end
                default: begin
                    b   = 4'b0001 << $urandom_range(0, 3);
                    len = $urandom_range(1, 12);
                    repeat (len) tick(b, 1'b0, rnd_rdy());
                    b = b | (4'b0001 << $urandom_range(0, 3));
                    repeat (5) tick(b, 1'b0, rnd_rdy());
                end
            endcase
        end
        idle(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
